cmp_share_arbiter: RTL
======================

CMP_SHARE_ARBITER -- requirements
Module: cmp_share_arbiter

Interface
REQ-001 Parameter N, default 8, operand width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; a power of 2, at least 2.
REQ-003 Parameter IDW, default $clog2(NUM_REQ), requester-ID width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester compare request.
REQ-007 req_a  input  NUM_REQ*N  packed operand A; requester i occupies bits [i*N +: N].
REQ-008 req_b  input  NUM_REQ*N  packed operand B; same packing as req_a.
REQ-009 req_ready  output  NUM_REQ  one-hot grant; operands are taken in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-010 rsp_valid  output  1  a result is available.
REQ-011 rsp_id  output  IDW  index of the requester that owns the result.
REQ-012 rsp_greater, rsp_lesser, rsp_equal  output  1 each  unsigned A>B, A<B, A==B.
REQ-013 rsp_ready  input  1  consumer accepts the result.

Function
REQ-014 FSM states: IDLE, CMP, RESP.
REQ-015 IDLE: if any req_valid is 1, the block grants the first valid requester found searching upward from rr_ptr, with wrap from NUM_REQ-1 to 0.
- req_ready is combinational and only nonzero in IDLE.
- On grant, operands and ID are latched and the FSM moves to CMP.
- With no request, the FSM stays in IDLE.
REQ-016 CMP: the comparison of the latched operands is registered into the result flags; the FSM moves to RESP in the next cycle.
REQ-017 RESP: rsp_valid is 1, and rsp_id and the flags are held stable until rsp_ready is 1.
- On the rsp_ready cycle: rr_ptr is set to (granted ID + 1) mod NUM_REQ and the FSM moves to IDLE.
REQ-018 Latency is fixed: a grant at cycle t gives rsp_valid=1 at cycle t+2. Peak throughput is one compare per 3 cycles.
REQ-019 Exactly one of rsp_greater, rsp_lesser, rsp_equal is 1 whenever rsp_valid is 1. All comparisons are unsigned over N bits.
REQ-020 While rsp_ready is 0 in RESP, req_ready stays all-zero (backpressure). No request is lost; pending requesters wait.
REQ-021 A requester SHALL hold req_valid and its operands stable until granted. Deasserting req_valid after the grant does not affect the result in flight.
REQ-022 If every requester is valid continuously, grants rotate 0,1,2,3,0,... Each requester waits at most NUM_REQ-1 transactions.
REQ-023 If rsp_ready is 1 on the first RESP cycle, rsp_valid lasts exactly one cycle.

Reset
REQ-024 When rst_n=0, immediately and regardless of clk:
- FSM=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, all flags=0, latched operands=0.
REQ-025 A reset in CMP or RESP drops the in-flight transaction without producing a response. Operation resumes from IDLE on the first rising edge after rst_n returns to 1.

Configuration
REQ-026 Macro CMP_ARB_COUNT_EN.
- Defined: the module adds output cmp_count, 16 bits. It resets to 0, increments on each rsp_valid&&rsp_ready handshake, and wraps from 0xFFFF to 0.
- Undefined: the port and its logic do not exist, and all other behaviour is identical.

Structure
REQ-027 Package cmp_arb_pkg holds:
- the FSM state enum (IDLE, CMP, RESP);
- default constants CMP_N=8 and CMP_NUM_REQ=4;
- the counter width constant CMP_CNT_W=16.
REQ-028 A single sub-module, cmp_core (parameter N, purely combinational greater/lesser/equal), SHALL be instantiated once and shared by all requesters. The round-robin pick is coded inline in the module.

Verification
REQ-029 Reset then single request: req_valid=4'b0010, a=8'h5A, b=8'h3C, rsp_ready=1 -> req_ready=4'b0010 at t, rsp_valid at t+2, rsp_id=1, greater=1, lesser=0, equal=0.
REQ-030 Equality and extremes:
- a=b=8'hFF -> equal=1.
- a=8'h00, b=8'hFF -> lesser=1.
- a=8'h80, b=8'h7F -> greater=1 (unsigned).
REQ-031 Fairness: all four req_valid held at 1, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, with grant cycles exactly 3 apart.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and flags held unchanged, req_ready=0 throughout. On release, the next grant goes to (id+1) mod 4.
REQ-033 Reset mid-flight: assert rst_n=0 during CMP -> all outputs 0 at once and no response appears. A request issued after reset is granted to the lowest-index valid requester (rr_ptr=0).
REQ-034 With CMP_ARB_COUNT_EN defined: 3 completed handshakes -> cmp_count=3. Force the count to 16'hFFFF, complete one more handshake -> cmp_count=0.

Source files
------------

// File: rtl/cmp_share_arbiter_pkg.sv
// Shared types and constants for the compare-share arbiter.
// Optional counter: define CMP_ARB_COUNT_EN to add the cmp_count port.
package cmp_arb_pkg;

    localparam int CMP_N       = 8;
    localparam int CMP_NUM_REQ = 4;
    localparam int CMP_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle between requesters, consumer and the arbiter.
// master: requester/consumer side; slave: arbiter side.
interface cmp_share_arbiter_if
    import cmp_arb_pkg::*;
#(
    parameter int N       = CMP_N,
    parameter int NUM_REQ = CMP_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_greater;
    logic                 rsp_lesser;
    logic                 rsp_equal;
    logic                 rsp_ready;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_greater,
        input  rsp_lesser,
        input  rsp_equal
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_greater,
        output rsp_lesser,
        output rsp_equal
    );

endinterface

// File: rtl/cmp_share_arbiter_core.sv
// Shared unsigned magnitude comparator, purely combinational.
// Exactly one of greater/lesser/equal is asserted for any operand pair.
module cmp_core
    import cmp_arb_pkg::*;
#(
    parameter int N = CMP_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         greater,
    output logic         lesser,
    output logic         equal
);

    always_comb begin
        greater = 1'b0;
        lesser  = 1'b0;
        equal   = 1'b0;
        unique case (1'b1)
            (a > b): greater = 1'b1;
            (a < b): lesser  = 1'b1;
            default: equal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one comparator among NUM_REQ requesters.
// Define CMP_ARB_COUNT_EN to add a 16-bit completed-handshake counter.
module cmp_share_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int N       = CMP_N,
    parameter int NUM_REQ = CMP_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmp_share_arbiter_if.slave   bus
`ifdef CMP_ARB_COUNT_EN
    ,
    output logic [CMP_CNT_W-1:0] cmp_count
`endif
);

    state_t               state_q;
    state_t               state_d;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       id_q;
    logic [N-1:0]         a_q;
    logic [N-1:0]         b_q;
    logic                 gt_q;
    logic                 lt_q;
    logic                 eq_q;
    logic                 gt_c;
    logic                 lt_c;
    logic                 eq_c;
    logic                 found;
    logic [IDW-1:0]       pick;
    logic [IDW-1:0]       idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 in_idle;
    logic                 in_cmp;
    logic                 in_resp;
    logic                 take;
    logic                 done;

    assign in_idle = (state_q == IDLE);
    assign in_cmp  = (state_q == CMP);
    assign in_resp = (state_q == RESP);
    assign take    = in_idle & found;
    assign done    = in_resp & bus.rsp_ready;

    // Search upward from rr_ptr; IDW-bit index wraps naturally.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        idx   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + IDW'(k);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) begin
            grant = NUM_REQ'(1) << pick;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = CMP;
                end
            end
            CMP: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            id_q <= '0;
        end else if (take) begin
            a_q  <= bus.req_a[pick*N +: N];
            b_q  <= bus.req_b[pick*N +: N];
            id_q <= pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else if (in_cmp) begin
            gt_q <= gt_c;
            lt_q <= lt_c;
            eq_q <= eq_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (done) begin
            rr_ptr <= id_q + IDW'(1);
        end
    end

    cmp_core #(
        .N (N)
    ) u_core (
        .a       (a_q),
        .b       (b_q),
        .greater (gt_c),
        .lesser  (lt_c),
        .equal   (eq_c)
    );

    // Outputs are gated so nothing stale leaks outside RESP.
    assign bus.req_ready   = in_idle ? grant : '0;
    assign bus.rsp_valid   = in_resp;
    assign bus.rsp_id      = in_resp ? id_q : '0;
    assign bus.rsp_greater = in_resp & gt_q;
    assign bus.rsp_lesser  = in_resp & lt_q;
    assign bus.rsp_equal   = in_resp & eq_q;

`ifdef CMP_ARB_COUNT_EN
    logic [CMP_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (done) begin
            cnt_q <= cnt_q + CMP_CNT_W'(1);
        end
    end

    assign cmp_count = cnt_q;
`endif

endmodule
